// File: rtl/apb_request_arbiter_if.sv
// Bundle between the requester agents, the round-robin arbiter and one APB slave.
// The slave modport is the arbiter side; the master modport is the agent/APB-slave environment.
interface apb_request_arbiter_if #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 7,
  parameter int BUS_WIDTH     = 32
);
  // Handshake: i_request[n] is a level held with a stable command until the single
  // o_ack[n] pulse; the requester must drop or change it on the cycle after o_ack.
  // o_read_data/o_error are meaningful only while some o_ack bit is high.
  logic [REQUESTERS-1:0]                 i_request;
  logic [REQUESTERS-1:0]                 i_write;
  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   i_address;
  logic [REQUESTERS*BUS_WIDTH-1:0]       i_write_data;
  logic [REQUESTERS*(BUS_WIDTH/8)-1:0]   i_strobe;
  logic [REQUESTERS-1:0]                 o_ack;
  logic [BUS_WIDTH-1:0]                  o_read_data;
  logic                                  o_error;

  logic                                  o_psel;
  logic                                  o_penable;
  logic                                  o_pwrite;
  logic [ADDRESS_WIDTH-1:0]              o_paddr;
  logic [BUS_WIDTH-1:0]                  o_pwdata;
  logic [BUS_WIDTH/8-1:0]                o_pstrb;
  logic                                  i_pready;
  logic                                  i_pslverr;
  logic [BUS_WIDTH-1:0]                  i_prdata;

  modport slave (
    input  i_request, i_write, i_address, i_write_data, i_strobe,
    output o_ack, o_read_data, o_error,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
    input  i_pready, i_pslverr, i_prdata
  );

  modport master (
    output i_request, i_write, i_address, i_write_data, i_strobe,
    input  o_ack, o_read_data, o_error,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
    output i_pready, i_pslverr, i_prdata
  );
endinterface

// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter sharing one APB master port among REQUESTERS single-beat agents.
// Optional access-phase timeout is enabled with `define APB_REQUEST_ARBITER_TIMEOUT_EN.
module apb_request_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  apb_request_arbiter_if.slave  bus,
  output logic [1:0]            o_state
);

  localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int SW = BUS_WIDTH / 8;
  localparam logic [GW-1:0] LAST_RESET = GW'(REQUESTERS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_e;

  state_e                   state_q,      state_d;
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic                     psel_q,       psel_d;
  logic                     penable_q,    penable_d;
  logic                     pwrite_q,     pwrite_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q,      paddr_d;
  logic [BUS_WIDTH-1:0]     pwdata_q,     pwdata_d;
  logic [SW-1:0]            pstrb_q,      pstrb_d;
  logic [REQUESTERS-1:0]    ack_q,        ack_d;
  logic [BUS_WIDTH-1:0]     rdata_q,      rdata_d;
  logic                     error_q,      error_d;

`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]            wait_cnt_q,   wait_cnt_d;
`endif

  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  int            cand_sum;

  // Search starts just after the last grant and wraps, so a busy agent cannot starve the others.
  always_comb begin
    winner   = last_grant_q;
    found    = 1'b0;
    cand     = '0;
    cand_sum = 0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      cand_sum = int'(last_grant_q) + i;
      if (cand_sum >= REQUESTERS) cand_sum = cand_sum - REQUESTERS;
      cand = GW'(cand_sum);
      if (!found && bus.i_request[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    error_d      = error_q;
`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          last_grant_d = winner;
          pwrite_d     = bus.i_write[winner];
          paddr_d      = bus.i_address[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          pwdata_d     = bus.i_write_data[winner*BUS_WIDTH +: BUS_WIDTH];
          pstrb_d      = bus.i_strobe[winner*SW +: SW];
          psel_d       = 1'b1;
          state_d      = SETUP;
        end
      end

      SETUP: begin
        penable_d  = 1'b1;
        state_d    = ACCESS;
`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ACCESS: begin
        if (bus.i_pready) begin
          rdata_d            = pwrite_q ? '0 : bus.i_prdata;
          error_d            = bus.i_pslverr;
          ack_d[last_grant_q] = 1'b1;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          state_d            = ACK;
        end
`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
        else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // A slave that never answers completes as an error; its late pready is never looked at.
          if (wait_cnt_d == CW'(TIMEOUT_CYCLES)) begin
            rdata_d             = '0;
            error_d             = 1'b1;
            ack_d[last_grant_q] = 1'b1;
            psel_d              = 1'b0;
            penable_d           = 1'b0;
            state_d             = ACK;
          end
        end
`endif
      end

      ACK: begin
        rdata_d = '0;
        error_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RESET;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.o_psel      = psel_q;
  assign bus.o_penable   = penable_q;
  assign bus.o_pwrite    = pwrite_q;
  assign bus.o_paddr     = paddr_q;
  assign bus.o_pwdata    = pwdata_q;
  assign bus.o_pstrb     = pstrb_q;
  assign bus.o_ack       = ack_q;
  assign bus.o_read_data = rdata_q;
  assign bus.o_error     = error_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Directed bench for apb_request_arbiter: two requesters, a behavioural APB slave and an
// expected-completion queue checked whenever an acknowledge appears.
module tb_apb_request_arbiter;

  localparam int R  = 2;
  localparam int AW = 7;
  localparam int BW = 32;
  localparam int SW = BW / 8;

  typedef struct packed {
    logic [R-1:0]  ack;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [BW-1:0] rdata;
    logic          err;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic          clk;
  logic          rst_n;
  logic [1:0]    dbg_state;
  logic [EW-1:0] exp_q[$];

  int            n_vec;
  int            n_bad;
  int            rep_left[R];
  int            slave_wait;
  int            wcnt;
  logic [BW-1:0] slave_rdata;
  logic          slave_err;

  apb_request_arbiter_if #(.REQUESTERS(R), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

  apb_request_arbiter #(
    .REQUESTERS(R), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // APB slave: pready after slave_wait access-phase cycles, data/error from the globals
  always @(negedge clk) begin
    if (bus.o_psel && bus.o_penable) begin
      bus.i_pready = (wcnt >= slave_wait);
      wcnt++;
    end else begin
      bus.i_pready = 1'b0;
      wcnt = 0;
    end
    bus.i_prdata  = slave_rdata;
    bus.i_pslverr = slave_err;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int r, input logic wr, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wd, input logic [SW-1:0] st,
                          input logic [BW-1:0] rd, input logic err);
    exp_t e;
    e.ack    = '0;
    e.ack[r] = 1'b1;
    e.pwrite = wr;
    e.paddr  = addr;
    e.pwdata = wd;
    e.pstrb  = st;
    e.rdata  = rd;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  // driver: present a command on requester r; expected result comes from the slave settings
  task automatic issue(input int r, input logic wr, input logic [AW-1:0] addr,
                       input logic [BW-1:0] wd, input logic [SW-1:0] st, input bit push);
    bus.i_write[r]                = wr;
    bus.i_address[r*AW +: AW]     = addr;
    bus.i_write_data[r*BW +: BW]  = wd;
    bus.i_strobe[r*SW +: SW]      = st;
    bus.i_request[r]              = 1'b1;
    if (push) push_exp(r, wr, addr, wd, st, wr ? '0 : slave_rdata, slave_err);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.i_request = '0;
    for (int i = 0; i < R; i++) rep_left[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard: walk negedges until an ack, checking APB command stability and the popped entry
  task automatic wait_ack(output int n, output int psel_at, output int pen_at);
    bit   got;
    exp_t e;
    n = 0; psel_at = 0; pen_at = 0; got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      if (bus.o_psel && psel_at == 0) psel_at = n;
      if (bus.o_penable && pen_at == 0) pen_at = n;
      if (bus.o_psel && bus.o_penable && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("access_paddr",  bus.o_paddr,  e.paddr);
        chk("access_pwrite", bus.o_pwrite, e.pwrite);
        chk("access_pwdata", bus.o_pwdata, e.pwdata);
        chk("access_pstrb",  bus.o_pstrb,  e.pstrb);
      end
      if (|bus.o_ack) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    if (got) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", bus.o_ack, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_vector", bus.o_ack,       e.ack);
        chk("ack_rdata",  bus.o_read_data, e.rdata);
        chk("ack_error",  bus.o_error,     e.err);
        chk("ack_psel",   bus.o_psel,      0);
        chk("ack_paddr",  bus.o_paddr,     e.paddr);
      end
      chk("ack_onehot", $onehot(bus.o_ack), 1);
      for (int i = 0; i < R; i++) begin
        if (bus.o_ack[i]) begin
          if (rep_left[i] > 0) rep_left[i]--;
          else bus.i_request[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n, pa, ea, k, w;
    logic wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wd;
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0;
    slave_wait = 0; slave_rdata = '0; slave_err = 1'b0; wcnt = 0;
    bus.i_request = '0; bus.i_write = '0; bus.i_address = '0;
    bus.i_write_data = '0; bus.i_strobe = '0;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_state",   dbg_state,       0);
    chk("rst_psel",    bus.o_psel,      0);
    chk("rst_penable", bus.o_penable,   0);
    chk("rst_ack",     bus.o_ack,       0);
    chk("rst_error",   bus.o_error,     0);
    chk("rst_rdata",   bus.o_read_data, 0);
    chk("rst_paddr",   bus.o_paddr,     0);
    chk("rst_pwdata",  bus.o_pwdata,    0);
    chk("rst_pstrb",   bus.o_pstrb,     0);
    chk("rst_pwrite",  bus.o_pwrite,    0);

    // single zero-wait read from requester 0
    slave_rdata = 32'h0000_00A5;
    @(posedge clk); #1;
    issue(0, 1'b0, 7'h04, 32'h0, 4'hF, 1'b1);
    wait_ack(n, pa, ea);
    chk("read_psel_cycle",    pa, 2);
    chk("read_penable_cycle", ea, 3);
    chk("read_ack_cycle",     n,  4);

    // simultaneous writes straight after reset: requester 0 first, then 1
    do_reset();
    slave_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    issue(0, 1'b1, 7'h00, 32'h1111_1111, 4'hF, 1'b1);
    issue(1, 1'b1, 7'h04, 32'h2222_2222, 4'h3, 1'b1);
    wait_ack(n, pa, ea);
    chk("simul_first_latency", n, 4);
    wait_ack(n, pa, ea);
    chk("simul_second_gap", n, 4);

    // continuous reads from both: grants alternate 0,1,0,1,0,1
    slave_rdata = 32'h1357_9BDF;
    rep_left[0] = 2; rep_left[1] = 2;
    @(posedge clk); #1;
    issue(0, 1'b0, 7'h08, 32'h0, 4'hF, 1'b0);
    issue(1, 1'b0, 7'h0C, 32'h0, 4'hF, 1'b0);
    for (int t = 0; t < 3; t++) begin
      push_exp(0, 1'b0, 7'h08, 32'h0, 4'hF, slave_rdata, 1'b0);
      push_exp(1, 1'b0, 7'h0C, 32'h0, 4'hF, slave_rdata, 1'b0);
    end
    for (int t = 0; t < 6; t++) begin
      wait_ack(n, pa, ea);
      chk("cont_spacing", n, 4);
    end

    // slave error after 3 wait states on a write from requester 1
    slave_wait = 3; slave_err = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b1, 7'h20, 32'hCAFE_F00D, 4'hC, 1'b1);
    wait_ack(n, pa, ea);
    chk("err_psel_cycle",    pa, 2);
    chk("err_penable_cycle", ea, 3);
    chk("err_ack_cycle",     n,  7);
    slave_wait = 0; slave_err = 1'b0;

    // assorted single transfers with random data and wait states
    for (int t = 0; t < 4; t++) begin
      k    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 127));
      wd   = $urandom;
      w    = int'($urandom_range(0, 2));
      slave_rdata = $urandom;
      slave_wait  = w;
      @(posedge clk); #1;
      issue(k, wr, addr, wd, 4'($urandom_range(0, 15)), 1'b1);
      wait_ack(n, pa, ea);
      chk("rand_ack_cycle", n, 4 + w);
    end
    slave_wait = 0;

    // reset in the middle of an access phase abandons the transfer
    slave_wait = 100;
    @(posedge clk); #1;
    issue(0, 1'b0, 7'h10, 32'h0, 4'hF, 1'b0);
    k = 0;
    while (!bus.o_penable && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reached_access", bus.o_penable, 1);
    rst_n = 1'b0;
    bus.i_request = '0;
    @(negedge clk);
    chk("midrst_psel",    bus.o_psel,    0);
    chk("midrst_penable", bus.o_penable, 0);
    chk("midrst_ack",     bus.o_ack,     0);
    chk("midrst_state",   dbg_state,     0);
    @(negedge clk);
    chk("midrst_ack_later", bus.o_ack, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    slave_wait = 0;
    issue(0, 1'b1, 7'h14, 32'hA5A5_0000, 4'hF, 1'b1);
    issue(1, 1'b1, 7'h18, 32'h0000_5A5A, 4'hF, 1'b1);
    wait_ack(n, pa, ea);
    chk("postrst_latency", n, 4);
    wait_ack(n, pa, ea);
    chk("postrst_second_gap", n, 4);

`ifdef APB_REQUEST_ARBITER_TIMEOUT_EN
    // slave never ready: completes as an error after 4 wait cycles
    slave_wait  = 1000;
    slave_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    issue(1, 1'b0, 7'h30, 32'h0, 4'hF, 1'b0);
    push_exp(1, 1'b0, 7'h30, 32'h0, 4'hF, 32'h0, 1'b1);
    wait_ack(n, pa, ea);
    chk("timeout_ack_cycle", n, 7);
    slave_wait = 0;
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
